// File: rtl/dlx_mem_pkg.sv
// -----------------------------------------------------------------------------
// dlx_mem_pkg
// Shared definitions for the DLX multiprocessor BRAM port sharing logic.
//   N_REQ      : number of requesting cores
//   AW / DW    : BRAM address / data width (8K x 16)
//   MAX_BURST  : longest locked run one requester may hold
//   state_e    : arbiter state (ARB = free arbitration, LOCKED = owner valid)
//   beat_t     : one memory beat as issued by a fetch controller
//   idx_w()    : width of a requester index (at least one bit)
// -----------------------------------------------------------------------------
package dlx_mem_pkg;

  localparam int N_REQ     = 2;
  localparam int AW        = 13;
  localparam int DW        = 16;
  localparam int MAX_BURST = 6;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } beat_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. The search starts at i_ptr and wraps
// modulo N; the first set request wins.
//   i_req  : request vector
//   i_ptr  : index with highest priority this cycle
//   o_gnt  : one-hot grant (all zero when no request)
//   o_idx  : index of the winner (0 when no request)
//   o_any  : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Shares BRAM port A between N_REQ fetch controllers. Round-robin, one beat per
// cycle, with an optional lock for back-to-back bursts of up to MAX_BURST beats.
//   i_clk / i_reset        : clock, synchronous active-high reset
//   i_req/i_lock/i_we      : per-requester beat request, keep-ownership, write
//   i_addr / i_wdata       : packed per-requester address and write data
//   o_gnt                  : one-hot combinational grant
//   o_rvalid / o_rdata     : read return, one cycle after the accepted beat
//   o_bram_*/i_bram_dout   : BRAM port A (1-cycle read latency)
//
// state  | meaning
// ARB    | free round-robin arbitration starting at r_rr_ptr
// LOCKED | only r_owner may be granted; dropping req returns to ARB
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int N_REQ     = dlx_mem_pkg::N_REQ,
  parameter int AW        = dlx_mem_pkg::AW,
  parameter int DW        = dlx_mem_pkg::DW,
  parameter int MAX_BURST = dlx_mem_pkg::MAX_BURST
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ-1:0]    i_lock,
  input  logic [N_REQ-1:0]    i_we,
  input  logic [N_REQ*AW-1:0] i_addr,
  input  logic [N_REQ*DW-1:0] i_wdata,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_rvalid,
  output logic [DW-1:0]       o_rdata,
  output logic                o_bram_en,
  output logic                o_bram_we,
  output logic [AW-1:0]       o_bram_addr,
  output logic [DW-1:0]       o_bram_din,
  input  logic [DW-1:0]       i_bram_dout
);

  import dlx_mem_pkg::*;

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_e             r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_owner;
  logic [CW-1:0]      r_burst_cnt;
  logic [N_REQ-1:0]   r_rvalid;
  logic [AW-1:0]      r_addr_q;
  logic [DW-1:0]      r_din_q;

  logic [N_REQ-1:0]   w_pick_gnt;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;
  logic [N_REQ-1:0]   w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_accept;
  logic               w_sel_we;
  logic [AW-1:0]      w_sel_addr;
  logic [DW-1:0]      w_sel_din;
  logic               w_hold;
  logic [IW-1:0]      w_next_ptr;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req (i_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Reset blocks all grants; in LOCKED a dropped owner request idles the port
  // instead of handing the cycle to someone else.
  always_comb begin
    w_gnt = '0;
    w_idx = r_owner;
    if (!i_reset) begin
      if (r_state == ARB) begin
        w_gnt = w_pick_any ? w_pick_gnt : '0;
        w_idx = w_pick_idx;
      end else if (i_req[r_owner]) begin
        w_gnt[r_owner] = 1'b1;
      end
    end
  end

  assign w_accept   = |w_gnt;
  assign w_sel_we   = i_we[w_idx];
  assign w_sel_addr = i_addr[int'(w_idx)*AW +: AW];
  assign w_sel_din  = i_wdata[int'(w_idx)*DW +: DW];
  // Extend the lock only while the burst has room for at least one more beat.
  assign w_hold     = w_accept && i_lock[w_idx] &&
                      ((int'(r_burst_cnt) + 1) < MAX_BURST);
  assign w_next_ptr = (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + IW'(1);

  assign o_gnt       = w_gnt;
  assign o_bram_en   = w_accept;
  assign o_bram_we   = w_accept & w_sel_we;
  assign o_bram_addr = w_accept ? w_sel_addr : r_addr_q;
  assign o_bram_din  = w_accept ? w_sel_din  : r_din_q;
  assign o_rvalid    = r_rvalid;
  // BRAM output is already registered; gate it so rdata is 0 when idle.
  assign o_rdata     = (|r_rvalid) ? i_bram_dout : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ARB;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_rvalid    <= '0;
      r_addr_q    <= '0;
      r_din_q     <= '0;
    end else begin
      r_rvalid <= (w_accept && !w_sel_we) ? w_gnt : '0;
      if (w_accept) begin
        r_addr_q <= w_sel_addr;
        r_din_q  <= w_sel_din;
        if (w_hold) begin
          r_state     <= LOCKED;
          r_owner     <= w_idx;
          r_burst_cnt <= r_burst_cnt + CW'(1);
        end else begin
          r_state     <= ARB;
          r_burst_cnt <= '0;
          r_rr_ptr    <= w_next_ptr;
        end
      end else if (r_state == LOCKED) begin
        r_state     <= ARB;
        r_burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed scenarios followed by randomized traffic. Grants and BRAM drive are
// compared against a behavioural model each cycle; expected read returns go
// into a scoreboard queue that a separate monitor drains against rvalid/rdata.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int MB = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    o_gnt, o_rvalid;
  logic [DW-1:0]   o_rdata, o_bram_din, bram_dout;
  logic            o_bram_en, o_bram_we;
  logic [AW-1:0]   o_bram_addr;

  always #5 clk = ~clk;

  bram_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_lock      (lock),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_gnt       (o_gnt),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_bram_en   (o_bram_en),
    .o_bram_we   (o_bram_we),
    .o_bram_addr (o_bram_addr),
    .o_bram_din  (o_bram_din),
    .i_bram_dout (bram_dout)
  );

  // BRAM environment model: registered read, 1-cycle latency
  logic [DW-1:0] bram_mem [0:8191];
  logic [DW-1:0] shadow   [0:8191];
  always @(posedge clk) begin
    if (o_bram_en) begin
      if (o_bram_we) bram_mem[o_bram_addr] <= o_bram_din;
      else           bram_dout <= bram_mem[o_bram_addr];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: ownership, beats taken in the current lock, next priority
  bit            m_locked;
  int            m_owner, m_beats, m_rr;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_din;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [N-1:0] model_gnt();
    int j;
    if (rst) return '0;
    if (m_locked) return req[m_owner] ? (N'(1) << m_owner) : '0;
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (req[j]) return N'(1) << j;
    end
    return '0;
  endfunction

  logic [N-1:0] last_gnt;

  task automatic cycle();
    logic [N-1:0]  eg;
    int            i;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    eg = model_gnt();
    @(negedge clk);
    last_gnt = o_gnt;
    chk("gnt", o_gnt, eg);
    chk("bram_en", o_bram_en, |eg);
    if (eg != 0) begin
      i = eg[1] ? 1 : 0;
      a = addr[i*AW +: AW];
      d = wdata[i*DW +: DW];
      chk("bram_we", o_bram_we, we[i]);
      chk("bram_addr", o_bram_addr, a);
      chk("bram_din", o_bram_din, d);
      if (we[i]) shadow[a] = d;
      else sbq.push_back('{i, shadow[a], cyc + 1});
      m_last_addr = a;
      m_last_din  = d;
      m_beats++;
      if (lock[i] && m_beats < MB) begin
        m_locked = 1'b1;
        m_owner  = i;
      end else begin
        m_locked = 1'b0;
        m_beats  = 0;
        m_rr     = (i + 1) % N;
      end
    end else begin
      chk("bram_we_idle", o_bram_we, 1'b0);
      if (!rst) begin
        chk("bram_addr_hold", o_bram_addr, m_last_addr);
        chk("bram_din_hold", o_bram_din, m_last_din);
      end
      m_locked = 1'b0;
      m_beats  = 0;
    end
    if (rst) begin
      m_locked = 1'b0; m_owner = 0; m_beats = 0; m_rr = 0;
      m_last_addr = '0; m_last_din = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                       input logic [1:0] w, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    rst = r; req = rq; lock = lk; we = w;
    addr = {a1, a0}; wdata = {d1, d0};
    cycle();
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  // Monitor: every read return must match the oldest scoreboard entry when due
  always @(negedge clk) begin
    logic [N-1:0] er;
    if (cyc > 0) begin
      er = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) er = N'(1) << sbq[0].idx;
      chk("rvalid", o_rvalid, er);
      if (er != 0) begin
        chk("rdata", o_rdata, sbq[0].data);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] pat [0:3];

  initial begin
    for (int i = 0; i < 8192; i++) begin
      bram_mem[i] = DW'(i * 7) ^ 16'h5a5a;
      shadow[i]   = DW'(i * 7) ^ 16'h5a5a;
    end
    bram_mem[5] = 16'h1234;
    shadow[5]   = 16'h1234;
    m_locked = 0; m_owner = 0; m_beats = 0; m_rr = 0;
    m_last_addr = '0; m_last_din = '0;
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

    do_reset();
    do_reset();
    chk("reset_gnt", last_gnt, 2'b00);
    chk("reset_rvalid", o_rvalid, 2'b00);
    chk("reset_rdata", o_rdata, 16'h0);
    chk("reset_addr", o_bram_addr, 13'h0);

    // Single read at 0x005
    drive(1'b0, 2'b01, 2'b00, 2'b00, 13'h005, '0, '0, '0);
    chk("single_gnt", last_gnt, 2'b01);
    req = '0; #3;
    chk("single_rvalid", o_rvalid, 2'b01);
    chk("single_rdata", o_rdata, 16'h1234);
    idle();

    // Contention without lock alternates starting at 0
    do_reset();
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b11, 2'b00, 2'b00, AW'(16 + k), AW'(32 + k), '0, '0);
      chk("contention_gnt", last_gnt, pat[k]);
    end
    idle();

    // Locked six-word fetch with forced release, then requester 1
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 2'b11, 2'b01, 2'b00, AW'(k), 13'h100, '0, '0);
      chk("locked_gnt0", last_gnt, 2'b01);
    end
    drive(1'b0, 2'b11, 2'b01, 2'b00, 13'h006, 13'h100, '0, '0);
    chk("locked_release_gnt1", last_gnt, 2'b10);
    idle();

    // Early unlock: one idle cycle, then requester 1
    do_reset();
    drive(1'b0, 2'b01, 2'b01, 2'b00, 13'h040, '0, '0, '0);
    drive(1'b0, 2'b01, 2'b01, 2'b00, 13'h041, '0, '0, '0);
    drive(1'b0, 2'b10, 2'b00, 2'b00, '0, 13'h050, '0, '0);
    chk("unlock_idle", last_gnt, 2'b00);
    drive(1'b0, 2'b10, 2'b00, 2'b00, '0, 13'h050, '0, '0);
    chk("unlock_gnt1", last_gnt, 2'b10);
    idle();

    // Reset mid-burst with rr_ptr previously moved to 1
    do_reset();
    drive(1'b0, 2'b01, 2'b00, 2'b00, 13'h060, '0, '0, '0);
    drive(1'b0, 2'b01, 2'b01, 2'b00, 13'h061, '0, '0, '0);
    drive(1'b0, 2'b01, 2'b01, 2'b00, 13'h062, '0, '0, '0);
    drive(1'b1, 2'b11, 2'b01, 2'b00, 13'h063, 13'h070, '0, '0);
    chk("midreset_gnt", last_gnt, 2'b00);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 13'h064, 13'h071, '0, '0);
    chk("postreset_gnt0", last_gnt, 2'b01);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 13'h065, 13'h072, '0, '0);
    chk("postreset_gnt1", last_gnt, 2'b10);
    idle();

    // Write 0xBEEF to 0x1FFF then read it back on requester 1
    drive(1'b0, 2'b10, 2'b00, 2'b10, '0, 13'h1FFF, '0, 16'hBEEF);
    chk("wr_gnt1", last_gnt, 2'b10);
    drive(1'b0, 2'b10, 2'b00, 2'b00, '0, 13'h1FFF, '0, '0);
    req = '0; #3;
    chk("rd_rvalid1", o_rvalid, 2'b10);
    chk("rd_rdata", o_rdata, 16'hBEEF);
    idle();

    // Randomized traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
            2'($urandom), 2'($urandom),
            {($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0},
            AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
            DW'($urandom), DW'($urandom));
    end
    idle();
    idle();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares the single-port 8K×16 data/instruction BRAM between N per-core fetch controllers in the DLX multiprocessor. Arbitration is round-robin, one beat per cycle, with an optional lock so a core can finish its six-word instruction fetch back-to-back. The block sits between the fetch controllers and the BRAM port-A signals (en/we/addr/din/dout). It forwards the registered read data to the winning requester one cycle later.

## Interface
- N_REQ, 2: number of requesting cores.
- AW, 13: BRAM address width.
- DW, 16: BRAM data width.
- MAX_BURST, 6: maximum consecutive locked beats one requester may hold.
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester beat request.
- lock  in  N_REQ  keep ownership after this beat.
- we  in  N_REQ  1 = write beat, 0 = read beat.
- addr  in  N_REQ*AW  packed addresses; requester i uses slice [i*AW +: AW].
- wdata  in  N_REQ*DW  packed write data.
- gnt  out  N_REQ  one-hot grant, combinational; the beat is accepted when req[i]&gnt[i].
- rvalid  out  N_REQ  one-hot; read data valid for requester i.
- rdata  out  DW  shared read data, qualified by rvalid.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  AW  BRAM address.
- bram_din  out  DW  BRAM write data.
- bram_dout  in  DW  BRAM read data, 1-cycle latency.

## Operation
- State machine with two states:
  - ARB: free arbitration.
  - LOCKED: owner register valid.
- ARB:
  - Search starts at rr_ptr and wraps modulo N_REQ.
  - The first i with req[i] set gets gnt[i]=1; all other gnt bits are 0.
  - No req: gnt=0 and bram_en=0.
- LOCKED:
  - Only the owner can be granted, and only while req[owner] is high.
  - Owner drops req: gnt=0 and the state returns to ARB next cycle. Those cycles are not granted to others.
- Accepted beat drives the BRAM outputs:
  - bram_en=1, bram_we=we[i], bram_addr=addr slice i, bram_din=wdata slice i.
  - With no accepted beat, bram_en=0, bram_we=0, and addr/din hold their last values.
- Lock handling on an accepted beat:
  - lock[i]=1 and burst_cnt+1 < MAX_BURST: go to LOCKED with owner=i and burst_cnt incremented. rr_ptr does not move.
  - Otherwise: go to ARB, burst_cnt=0, rr_ptr=(i+1) mod N_REQ.
  - Reaching MAX_BURST beats therefore forces a release even if lock stays high.
- Read beats:
  - The cycle after acceptance, rvalid[i]=1 and rdata=bram_dout.
  - Write beats never raise rvalid.
- burst_cnt width is clog2(MAX_BURST+1). It never exceeds MAX_BURST-1.
- Reset values:
  - state ARB, rr_ptr 0, owner 0, burst_cnt 0.
  - rvalid 0, rdata 0, bram_we 0, bram_en 0 (combinationally, since reset blocks grants), bram_addr 0, bram_din 0.
  - gnt is 0 while reset is high.
- Reset mid-burst: lock ownership is dropped immediately. A pending rvalid from the beat in the reset cycle is suppressed.

## Timing
- Grant and BRAM drive are combinational from req, state and rr_ptr, in the same cycle.
- Read latency: accept in cycle T gives rvalid/rdata in T+1. Back-to-back reads give one rvalid per cycle.
- Throughput: one beat per cycle with no bubble between owners in ARB.
- Locked burst of k beats takes k consecutive cycles if req is held.
- Release: a lock ending on beat k lets another requester win in cycle k+1.
- Simultaneous requests: rr_ptr decides. After a non-locked grant to i, i has lowest priority next.
- Write then read to the same address in consecutive cycles returns the new data (BRAM write-first is irrelevant; the read happens a cycle later).

## Structure
- Shared package (dlx_mem_pkg): AW, DW, the state enum {ARB, LOCKED}, and a beat struct {we, addr, wdata}.
- One sub-module: rr_pick, a combinational rotate-priority picker (req, ptr → one-hot grant, index).
- Top level: FSM, counters, mux and the rvalid pipeline register.

## Test plan
- Single read: reset, then req0 read at addr 0x005 with mem[5]=0x1234 → gnt0 in the same cycle, rvalid0=1 and rdata=0x1234 next cycle, rvalid1=0.
- Contention: req0 and req1 both held for 4 reads with lock=0 → grants alternate 0,1,0,1 starting with 0 after reset. Each rvalid lands on its owner one cycle later.
- Locked fetch: req0 with lock=1 for 6 beats at addr 0..5 while req1 is held → gnt0 for 6 consecutive cycles (forced release at MAX_BURST), then gnt1 on cycle 7.
- Early unlock: req0 with lock=1 for 2 beats, then req0 drops → one idle cycle with gnt=0, then req1 is granted.
- Reset mid-burst: assert reset on the 3rd locked beat of req0 → next cycle state ARB, burst_cnt 0, rvalid 0, and req1 can be granted with rr_ptr=0 priority.
- Write/read: req1 writes 0xBEEF to 0x1FFF, then reads 0x1FFF → no rvalid for the write, and rdata=0xBEEF with rvalid1 one cycle after the read grant.
